// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and bit-timing derivation.
// Used by both transmitter and receiver so the two ends agree on framing.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Integer-truncated; callers must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request / status / serial-line bundle between a UART transmitter and its client.
// The master side is the client; the slave side is the transmitter.
interface uart_tx_if;

  logic [7:0] data_in;
  logic       send_in;
  logic       busy_out;
  logic       done_out;
  logic       tx_out;

  modport master (
    output data_in,
    output send_in,
    input  busy_out,
    input  done_out,
    input  tx_out
  );

  modport slave (
    input  data_in,
    input  send_in,
    output busy_out,
    output done_out,
    output tx_out
  );

endinterface

// File: rtl/uart_tx_baud_tick_gen.sv
// Clear/enable bit-period counter; bit_end strobes for one cycle on the last count of each bit.
// Zero latency from count to strobe; clr wins over en and restarts the period at 0.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; registered outputs.
// First start-bit cycle follows the accept edge; requests while busy are dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic      clk_in,
  input logic      rst_in,
  uart_tx_if.slave bus
);

  localparam int         CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       par_bit;
  logic       accept;
  logic       baud_en;
  logic       bit_end;
  logic       tx_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  assign accept  = (state == ST_IDLE) && bus.send_in;
  assign baud_en = (state != ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk    (clk_in),
    .rst    (rst_in),
    .clr    (accept),
    .en     (baud_en),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA:   if (bit_end && bit_idx == 3'd7)
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end && bit_idx == LAST_STOP) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed for the cycle being entered, then registered, so
  // tx_out must look ahead to the post-shift LSB when a data bit ends.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_STOP) && (state_nxt == ST_IDLE);
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = (state == ST_DATA && bit_end) ? shreg[1] : shreg[0];
      ST_PARITY: tx_nxt = par_bit;
      default:   tx_nxt = 1'b1;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else if (accept) begin
      shreg   <= bus.data_in;
      bit_idx <= '0;
      par_bit <= (^bus.data_in) ^ PAR_INV;
    end else if (bit_end) begin
      if (state == ST_DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= (bit_idx == 3'd7) ? 3'd0 : 3'(bit_idx + 3'd1);
      end else if (state == ST_STOP) begin
        bit_idx <= (bit_idx == LAST_STOP) ? 3'd0 : 3'(bit_idx + 3'd1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.tx_out   <= 1'b1;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
    end else begin
      bus.tx_out   <= tx_nxt;
      bus.busy_out <= busy_nxt;
      bus.done_out <= done_nxt;
    end
  end

endmodule
